// File: rtl/top_example_axi_mem_responder.sv
// AXI4 slave memory responder: word-addressed BRAM model behind a reduced
// AXI4 port. Independent read and write FSMs; the word index wraps at the
// memory depth and the low byte-offset address bits are ignored.
module top_example_axi_mem_responder #(
    parameter int C_S_AXI_ADDR_WIDTH = 64,
    parameter int C_S_AXI_DATA_WIDTH = 512,
    parameter int C_MEM_DEPTH_WORDS  = 1024
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              s_axi_awvalid,
    output logic                              s_axi_awready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                        s_axi_awlen,
    input  logic                              s_axi_wvalid,
    output logic                              s_axi_wready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                              s_axi_wlast,
    output logic                              s_axi_bvalid,
    input  logic                              s_axi_bready,
    input  logic                              s_axi_arvalid,
    output logic                              s_axi_arready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                        s_axi_arlen,
    output logic                              s_axi_rvalid,
    input  logic                              s_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic                              s_axi_rlast,
    output logic                              err_wlast
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int OFFS_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(C_MEM_DEPTH_WORDS);

    typedef enum logic {R_IDLE, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [C_S_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH_WORDS];

    r_state_t          r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [7:0]        r_cnt;
    w_state_t          w_state;
    logic [IDX_W-1:0]  w_idx;
    logic [7:0]        w_cnt;

    logic [IDX_W-1:0]  ar_idx;
    logic [IDX_W-1:0]  aw_idx;
    logic [IDX_W-1:0]  r_idx_next;
    logic              w_fire;
    logic              unused_addr_bits;

    assign ar_idx     = s_axi_araddr[OFFS_W +: IDX_W];
    assign aw_idx     = s_axi_awaddr[OFFS_W +: IDX_W];
    assign r_idx_next = r_idx + 1'b1;
    assign w_fire     = s_axi_wvalid && s_axi_wready;

    // Byte offset and out-of-range upper address bits play no part in addressing
    assign unused_addr_bits = ^{s_axi_araddr[OFFS_W-1:0],
                                s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:OFFS_W+IDX_W],
                                s_axi_awaddr[OFFS_W-1:0],
                                s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:OFFS_W+IDX_W]};

    // Memory array: byte-lane write on each accepted W beat, never cleared
    always_ff @(posedge aclk) begin
        if (w_fire) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read FSM: prefetch the first word on AR, then advance one word per R handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= R_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            s_axi_arready <= 1'b1;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rdata   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_idx         <= ar_idx;
                        r_cnt         <= s_axi_arlen;
                        s_axi_rdata   <= mem[ar_idx];
                        s_axi_rlast   <= (s_axi_arlen == 8'd0);
                        s_axi_rvalid  <= 1'b1;
                        s_axi_arready <= 1'b0;
                        r_state       <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_idx       <= r_idx_next;
                            r_cnt       <= r_cnt - 8'd1;
                            s_axi_rdata <= mem[r_idx_next];
                            s_axi_rlast <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: begin
                    r_state       <= R_IDLE;
                    s_axi_arready <= 1'b1;
                    s_axi_rvalid  <= 1'b0;
                    s_axi_rlast   <= 1'b0;
                end
            endcase
        end
    end

    // Write FSM: burst length follows awlen; wlast is only checked, never obeyed
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state       <= W_IDLE;
            w_idx         <= '0;
            w_cnt         <= '0;
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            err_wlast     <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s_axi_awvalid && s_axi_awready) begin
                        w_idx         <= aw_idx;
                        w_cnt         <= s_axi_awlen;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (s_axi_wlast != (w_cnt == 8'd0)) begin
                            err_wlast <= 1'b1;
                        end
                        w_idx <= w_idx + 1'b1;
                        w_cnt <= w_cnt - 8'd1;
                        if (w_cnt == 8'd0) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bvalid && s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: begin
                    w_state       <= W_IDLE;
                    s_axi_awready <= 1'b1;
                    s_axi_wready  <= 1'b0;
                    s_axi_bvalid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_example_axi_mem_responder.sv
// Self-checking bench for the AXI4 memory responder: directed scenarios plus
// randomized bursts checked against a word-array model of the memory.
module tb_top_example_axi_mem_responder;

    localparam int DEPTH = 1024;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b1;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [63:0]  s_axi_awaddr = '0;
    logic [7:0]   s_axi_awlen = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [511:0] s_axi_wdata = '0;
    logic [63:0]  s_axi_wstrb = '0;
    logic         s_axi_wlast = 1'b0;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [63:0]  s_axi_araddr = '0;
    logic [7:0]   s_axi_arlen = '0;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b0;
    logic [511:0] s_axi_rdata;
    logic         s_axi_rlast;
    logic         err_wlast;

    int errors = 0;
    int checks = 0;

    logic [511:0] ref_mem [DEPTH];
    logic [511:0] wdata_q [256];
    logic [63:0]  wstrb_q [256];

    top_example_axi_mem_responder dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rlast   (s_axi_rlast),
        .err_wlast     (err_wlast)
    );

    // Free-running clock
    always #5 aclk = ~aclk;

    function automatic logic [511:0] randWord();
        logic [511:0] w;
        for (int k = 0; k < 16; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write burst from wdata_q/wstrb_q; bad_beat>=0 puts wlast on that beat only
    task automatic applyWriteBurst(input logic [63:0] addr, input int len,
                                   input int bad_beat, input int bready_delay);
        int base;
        int cyc;
        int idx;
        base = int'(addr[15:6]);
        @(negedge aclk);
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = addr;
        s_axi_awlen   = 8'(len);
        s_axi_bready  = (bready_delay == 0);
        cyc = 0;
        while (!s_axi_awready && cyc < 50) begin @(negedge aclk); cyc++; end
        checkOutput("aw_ready", {511'b0, s_axi_awready}, 512'd1);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wdata_q[i];
            s_axi_wstrb  = wstrb_q[i];
            s_axi_wlast  = (bad_beat < 0) ? (i == len) : (i == bad_beat);
            cyc = 0;
            while (!s_axi_wready && cyc < 50) begin @(negedge aclk); cyc++; end
            checkOutput("w_ready", {511'b0, s_axi_wready}, 512'd1);
            idx = (base + i) % DEPTH;
            for (int b = 0; b < 64; b++)
                if (wstrb_q[i][b]) ref_mem[idx][b*8 +: 8] = wdata_q[i][b*8 +: 8];
            @(negedge aclk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        checkOutput("b_valid_rise", {511'b0, s_axi_bvalid}, 512'd1);
        checkOutput("w_ready_in_resp", {511'b0, s_axi_wready}, 512'd0);
        for (int d = 0; d < bready_delay; d++) begin
            @(negedge aclk);
            checkOutput("b_valid_hold", {511'b0, s_axi_bvalid}, 512'd1);
        end
        s_axi_bready = 1'b1;
        @(negedge aclk);
        checkOutput("b_valid_drop", {511'b0, s_axi_bvalid}, 512'd0);
        checkOutput("aw_ready_back", {511'b0, s_axi_awready}, 512'd1);
        s_axi_bready = 1'b0;
    endtask

    // Read burst; mode 0 rready always 1, mode 1 toggles, mode 2 random
    task automatic applyReadBurst(input logic [63:0] addr, input int len, input int mode);
        int base;
        int beat;
        int cyc;
        base = int'(addr[15:6]);
        @(negedge aclk);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arlen   = 8'(len);
        cyc = 0;
        while (!s_axi_arready && cyc < 50) begin @(negedge aclk); cyc++; end
        checkOutput("ar_ready", {511'b0, s_axi_arready}, 512'd1);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        checkOutput("r_first_latency", {511'b0, s_axi_rvalid}, 512'd1);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 2000) begin
            if (mode == 0)      s_axi_rready = 1'b1;
            else if (mode == 1) s_axi_rready = (cyc % 2 == 0);
            else                s_axi_rready = 1'($urandom_range(0, 1));
            checkOutput("r_valid", {511'b0, s_axi_rvalid}, 512'd1);
            checkOutput("r_data", s_axi_rdata, ref_mem[(base + beat) % DEPTH]);
            checkOutput("r_last", {511'b0, s_axi_rlast}, {511'b0, beat == len});
            if (s_axi_rready) beat++;
            @(negedge aclk);
            cyc++;
        end
        s_axi_rready = 1'b0;
        checkOutput("r_beat_count", 512'(beat), 512'(len + 1));
        checkOutput("r_valid_drop", {511'b0, s_axi_rvalid}, 512'd0);
    endtask

    initial begin
        logic [63:0]  addr;
        logic [511:0] ones;
        int           len;
        int           cyc;

        // Reset: the asynchronous edge plus clock edges while held low
        #3 aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        checkOutput("rst_awready", {511'b0, s_axi_awready}, 512'd1);
        checkOutput("rst_arready", {511'b0, s_axi_arready}, 512'd1);
        checkOutput("rst_wready",  {511'b0, s_axi_wready},  512'd0);
        checkOutput("rst_bvalid",  {511'b0, s_axi_bvalid},  512'd0);
        checkOutput("rst_rvalid",  {511'b0, s_axi_rvalid},  512'd0);
        checkOutput("rst_rlast",   {511'b0, s_axi_rlast},   512'd0);
        checkOutput("rst_rdata",   s_axi_rdata,             512'd0);
        checkOutput("rst_err",     {511'b0, err_wlast},     512'd0);
        aresetn = 1'b1;

        // W beats offered before any AW must not be accepted
        @(negedge aclk);
        s_axi_wvalid = 1'b1;
        s_axi_wdata  = randWord();
        s_axi_wstrb  = '1;
        repeat (3) begin
            @(negedge aclk);
            checkOutput("w_idle_not_ready", {511'b0, s_axi_wready}, 512'd0);
        end
        s_axi_wvalid = 1'b0;

        // Fill the whole memory so every later read has a known value
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin
                wdata_q[i] = randWord();
                wstrb_q[i] = '1;
            end
            applyWriteBurst(64'(blk * 256 * 64), 255, -1, 0);
        end

        // Basic 4-beat write of 1..4 then read back
        for (int i = 0; i < 4; i++) begin
            wdata_q[i] = 512'(i + 1);
            wstrb_q[i] = '1;
        end
        applyWriteBurst(64'h0, 3, -1, 0);
        checkOutput("err_after_good", {511'b0, err_wlast}, 512'd0);
        applyReadBurst(64'h0, 3, 0);

        // Partial strobe on word 0
        ones = '1;
        wdata_q[0] = ones;
        wstrb_q[0] = '1;
        applyWriteBurst(64'h0, 0, -1, 1);
        wdata_q[0] = '0;
        wstrb_q[0] = 64'h1;
        applyWriteBurst(64'h0, 0, -1, 0);
        applyReadBurst(64'h0, 0, 0);
        ones[7:0] = 8'h00;
        checkOutput("partial_strobe_word", s_axi_rdata, ones);

        // Wrap from the last word back to word 0
        wdata_q[0] = randWord();
        wdata_q[1] = randWord();
        wstrb_q[0] = '1;
        wstrb_q[1] = '1;
        applyWriteBurst(64'(1023 * 64), 1, -1, 0);
        applyReadBurst(64'(1023 * 64), 1, 0);
        applyReadBurst(64'h0, 0, 0);
        checkOutput("wrap_word0", s_axi_rdata, wdata_q[1]);

        // Read backpressure, rready toggling
        applyReadBurst(64'h1000, 7, 1);

        // wlast early on the second beat of a 4-beat burst
        for (int i = 0; i < 4; i++) begin
            wdata_q[i] = randWord();
            wstrb_q[i] = '1;
        end
        applyWriteBurst(64'h2000, 3, 1, 0);
        checkOutput("err_wlast_set", {511'b0, err_wlast}, 512'd1);
        applyReadBurst(64'h2000, 3, 0);
        checkOutput("err_wlast_sticky", {511'b0, err_wlast}, 512'd1);

        // Reset in the middle of a read burst
        @(negedge aclk);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = 64'h100;
        s_axi_arlen   = 8'd7;
        cyc = 0;
        while (!s_axi_arready && cyc < 50) begin @(negedge aclk); cyc++; end
        checkOutput("mid_rst_ar_ready", {511'b0, s_axi_arready}, 512'd1);
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        repeat (3) @(negedge aclk);
        checkOutput("mid_rst_busy", {511'b0, s_axi_rvalid}, 512'd1);
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid", {511'b0, s_axi_rvalid}, 512'd0);
        checkOutput("mid_rst_rlast",  {511'b0, s_axi_rlast},  512'd0);
        checkOutput("mid_rst_err",    {511'b0, err_wlast},    512'd0);
        @(negedge aclk);
        aresetn      = 1'b1;
        s_axi_rready = 1'b0;
        @(negedge aclk);
        checkOutput("post_rst_arready", {511'b0, s_axi_arready}, 512'd1);
        checkOutput("post_rst_rvalid",  {511'b0, s_axi_rvalid},  512'd0);
        applyReadBurst(64'h100, 7, 0);

        // Randomized bursts against the model
        for (int it = 0; it < 12; it++) begin
            addr = {48'h0, 6'($urandom_range(0, 63)) * 0 + 6'(0), 10'(0)};
            addr[15:6] = 10'($urandom_range(0, DEPTH - 1));
            addr[5:0]  = 6'($urandom_range(0, 63));
            len = $urandom_range(0, 15);
            for (int i = 0; i <= len; i++) begin
                wdata_q[i] = randWord();
                wstrb_q[i] = {$urandom, $urandom};
            end
            applyWriteBurst(addr, len, -1, $urandom_range(0, 3));
            applyReadBurst(addr, len, 2);
            addr[15:6] = 10'($urandom_range(0, DEPTH - 1));
            applyReadBurst(addr, $urandom_range(0, 7), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
